decode_frame_ctrl: RTL and testbench
====================================

Name: decode_frame_ctrl

Overview:
Frame sequencer in front of the RX decode chain (deinterleaver_2 → deinterleaver_1 → S2P → decoder → descrambler).
- Accepts one frame configuration (data-symbol count, Map_Type) per frame.
- Gates the serial coded-bit stream into the chain and stamps each bit with symbol index and Map_Type.
- Watches the descrambler output for the frame's final bit, then reports done or error.
- Only one frame is in the chain at a time.

Parameters:
TIMEOUT_CYC, 4096, max cycles without progress (FEED handshake or DRAIN last) before error
CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_vld  in  1  frame config valid
cfg_rdy  out  1  config accepted when cfg_vld&cfg_rdy
cfg_n_symb  in  8  data symbols in frame, 1..255
cfg_map_type  in  2  0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM
abort  in  1  synchronous abort pulse
s_din  in  1  coded bit from demapper
s_din_vld  in  1  upstream valid
s_din_rdy  out  1  upstream ready
dec_din  out  1  bit to deinterleaver_2
dec_din_vld  out  1  valid to deinterleaver_2
dec_din_rdy  in  1  ready from deinterleaver_2
dec_symb_cnt  out  8  symbol index of current bit, 0-based
dec_map_type  out  2  latched Map_Type
mon_vld  in  1  descrambler output valid
mon_rdy  in  1  descrambler output ready (sink side)
mon_last  in  1  descrambler last flag
mon_symb_cnt  in  8  descrambler symbol count
frame_busy  out  1  high in FEED/DRAIN
frame_done  out  1  one-cycle pulse, frame completed
frame_err  out  1  one-cycle pulse, bad config or timeout

Behaviour:
- Reset / abort:
  - Reset: state IDLE; all counters 0; latched cfg 0; every output 0 except cfg_rdy=1.
  - abort (any state): next cycle IDLE, counters cleared, no done/err pulse. abort wins over every simultaneous event.
- NCBPS from latched map: 48/96/192/288 for map 0/1/2/3. bit_cnt is 9 bits, wraps at NCBPS-1.
- IDLE:
  - cfg_rdy=1, s_din_rdy=0, dec_din_vld=0.
  - On cfg_vld with cfg_n_symb==0: → ERR.
  - On cfg_vld otherwise: latch n_symb and map, clear bit_cnt/symb_cnt/watchdog, → FEED.
- FEED: combinational pass-through, zero latency.
  - dec_din=s_din, dec_din_vld=s_din_vld, s_din_rdy=dec_din_rdy.
  - dec_symb_cnt=symb_cnt, dec_map_type=latched map.
  - On handshake (s_din_vld&dec_din_rdy): bit_cnt++. At bit_cnt==NCBPS-1: bit_cnt←0, symb_cnt++.
  - At last bit of symbol n_symb-1: → DRAIN; symb_cnt holds n_symb-1.
  - cfg_rdy=0.
  - mon_* ignored in FEED.
- DRAIN:
  - s_din_rdy=0, dec_din_vld=0.
  - Completion is mon_vld&mon_rdy&mon_last with mon_symb_cnt==n_symb-1 → DONE.
  - A last flag with a mismatched count is ignored.
- DONE: frame_done=1 for one cycle, → IDLE. cfg_rdy=0 this cycle.
- ERR: frame_err=1 for one cycle, → IDLE.
- Watchdog:
  - Counts in FEED/DRAIN; cleared on any FEED handshake or on state entry.
  - Reaching TIMEOUT_CYC-1 → ERR. A progress event in the same cycle takes priority over the timeout.
- frame_busy is registered from state: 1 in FEED/DRAIN, 0 otherwise.
- No bits are accepted from upstream outside FEED.
- The cfg handshake is never accepted outside IDLE.

Test Plan:
1. BPSK, n_symb=2, continuous valid/ready → exactly 96 bits forwarded; dec_symb_cnt=0 for bits 0–47 and 1 for bits 48–95; s_din_rdy drops after bit 95; mon_last with symb_cnt=1 → frame_done one cycle later; cfg_rdy back to 1.
2. 64QAM, n_symb=3, random dec_din_rdy backpressure → 864 handshakes, no bit dropped or duplicated; symbol boundary at bit 288 correct under stalls.
3. cfg_n_symb=0 → frame_err pulse, no FEED entry, s_din_rdy stays 0.
4. DRAIN with mon_last at symb_cnt=0 when n_symb=2 → ignored; no progress for TIMEOUT_CYC cycles → frame_err, return to IDLE.
5. abort mid-FEED (QPSK, bit 50) → next cycle IDLE, no pulses; a fresh config is accepted and counts restart at 0.
6. rst asserted mid-DRAIN → all outputs reset immediately (asynchronously), cfg_rdy=1 after release.

Source files
------------

// File: rtl/decode_frame_ctrl.sv
// Frame sequencer for the RX decode chain: gates coded bits in,
// stamps symbol index / Map_Type, and waits for the descrambler's last bit.
module decode_frame_ctrl #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_vld,
  output logic       cfg_rdy,
  input  logic [7:0] cfg_n_symb,
  input  logic [1:0] cfg_map_type,
  input  logic       abort,
  input  logic       s_din,
  input  logic       s_din_vld,
  output logic       s_din_rdy,
  output logic       dec_din,
  output logic       dec_din_vld,
  input  logic       dec_din_rdy,
  output logic [7:0] dec_symb_cnt,
  output logic [1:0] dec_map_type,
  input  logic       mon_vld,
  input  logic       mon_rdy,
  input  logic       mon_last,
  input  logic [7:0] mon_symb_cnt,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, FEED, DRAIN, DONE, ERR
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       n_symb, symb_cnt, last_symb;
  logic [1:0]       map_q;
  logic [8:0]       bit_cnt, ncbps_m1;
  logic [CNT_W-1:0] wdog;
  logic             hs, sym_end, frm_end, mon_hit, wd_exp;

  always_comb begin
    ncbps_m1 = 9'd47;
    unique case (map_q)
      2'd0: ncbps_m1 = 9'd47;
      2'd1: ncbps_m1 = 9'd95;
      2'd2: ncbps_m1 = 9'd191;
      2'd3: ncbps_m1 = 9'd287;
      default: ncbps_m1 = 9'd47;
    endcase
  end

  assign last_symb = n_symb - 8'd1;
  assign hs      = (state == FEED) && s_din_vld && dec_din_rdy;
  assign sym_end = (bit_cnt == ncbps_m1);
  assign frm_end = hs && sym_end && (symb_cnt == last_symb);
  assign mon_hit = (state == DRAIN) && mon_vld && mon_rdy
                && mon_last && (mon_symb_cnt == last_symb);
  assign wd_exp  = (wdog == CNT_W'(TIMEOUT_CYC - 1));

  // State register; busy is derived from the next state so it
  // lines up exactly with FEED/DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_busy <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_busy <= (state_nx == FEED) || (state_nx == DRAIN);
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (cfg_vld)
            state_nx = (cfg_n_symb == 8'd0) ? ERR : FEED;
        FEED:
          if (frm_end)         state_nx = DRAIN;
          else if (!hs && wd_exp) state_nx = ERR;
        DRAIN:
          if (mon_hit)         state_nx = DONE;
          else if (wd_exp)     state_nx = ERR;
        DONE:    state_nx = IDLE;
        ERR:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_symb   <= '0;
      map_q    <= '0;
      bit_cnt  <= '0;
      symb_cnt <= '0;
      wdog     <= '0;
    end else if (abort) begin
      bit_cnt  <= '0;
      symb_cnt <= '0;
      wdog     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (cfg_vld && cfg_n_symb != 8'd0) begin
            n_symb   <= cfg_n_symb;
            map_q    <= cfg_map_type;
            bit_cnt  <= '0;
            symb_cnt <= '0;
          end
        end
        FEED: begin
          if (hs) begin
            wdog <= '0;
            if (sym_end) begin
              bit_cnt <= '0;
              if (!frm_end) symb_cnt <= symb_cnt + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DRAIN:
          wdog <= mon_hit ? '0 : wdog + 1'b1;
        default:
          wdog <= '0;
      endcase
    end
  end

  always_comb begin
    cfg_rdy     = 1'b0;
    s_din_rdy   = 1'b0;
    dec_din     = 1'b0;
    dec_din_vld = 1'b0;
    frame_done  = 1'b0;
    frame_err   = 1'b0;
    unique case (state)
      IDLE: cfg_rdy = 1'b1;
      FEED: begin
        dec_din     = s_din;
        dec_din_vld = s_din_vld;
        s_din_rdy   = dec_din_rdy;
      end
      DONE:    frame_done = 1'b1;
      ERR:     frame_err  = 1'b1;
      default: ;
    endcase
  end

  assign dec_symb_cnt = symb_cnt;
  assign dec_map_type = map_q;

endmodule

// File: tb/tb_decode_frame_ctrl.sv
// Bench for decode_frame_ctrl: vector table, directed frame sequences
// and randomized frames against a bit-index reference model.
module tb_decode_frame_ctrl;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_vld, cfg_rdy;
  logic [7:0] cfg_n_symb;
  logic [1:0] cfg_map_type;
  logic       abort;
  logic       s_din, s_din_vld, s_din_rdy;
  logic       dec_din, dec_din_vld, dec_din_rdy;
  logic [7:0] dec_symb_cnt;
  logic [1:0] dec_map_type;
  logic       mon_vld, mon_rdy, mon_last;
  logic [7:0] mon_symb_cnt;
  logic       frame_busy, frame_done, frame_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_frame_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_n_symb(cfg_n_symb), .cfg_map_type(cfg_map_type),
    .abort(abort),
    .s_din(s_din), .s_din_vld(s_din_vld), .s_din_rdy(s_din_rdy),
    .dec_din(dec_din), .dec_din_vld(dec_din_vld),
    .dec_din_rdy(dec_din_rdy),
    .dec_symb_cnt(dec_symb_cnt), .dec_map_type(dec_map_type),
    .mon_vld(mon_vld), .mon_rdy(mon_rdy), .mon_last(mon_last),
    .mon_symb_cnt(mon_symb_cnt),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  typedef struct {
    logic       cv;
    logic [7:0] n;
    logic [1:0] mt;
    logic       sv;
    logic       dr;
    logic       ab;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ncbps(input int mt);
    case (mt)
      0: return 48;
      1: return 96;
      2: return 192;
      default: return 288;
    endcase
  endfunction

  task automatic clear_in();
    cfg_vld = 0; cfg_n_symb = 0; cfg_map_type = 0; abort = 0;
    s_din = 0; s_din_vld = 0; dec_din_rdy = 0;
    mon_vld = 0; mon_rdy = 0; mon_last = 0; mon_symb_cnt = 0;
  endtask

  task automatic start_cfg(input int n, input int mt);
    @(negedge clk);
    cfg_vld = 1; cfg_n_symb = 8'(n); cfg_map_type = 2'(mt);
    s_din_vld = 1; dec_din_rdy = 1;
    #1;
    chk("cfg_rdy_idle", cfg_rdy, 1);
    chk("s_rdy_idle", s_din_rdy, 0);
    @(posedge clk); #1;
    clear_in();
    chk("cfg_busy", frame_busy, n != 0);
    chk("cfg_err", frame_err, n == 0);
  endtask

  // Model: the k-th accepted bit of a frame belongs to symbol k/NCBPS.
  task automatic feed(input int n, input int mt,
                      input int stop_at, input bit rnd);
    int k = 0;
    int cyc = 0;
    int nc = ncbps(mt);
    while (k < stop_at) begin
      @(negedge clk);
      s_din = 1'($urandom);
      s_din_vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dec_din_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      mon_vld = rnd ? 1'($urandom) : 1'b0;
      mon_rdy = rnd ? 1'($urandom) : 1'b0;
      mon_last = rnd ? 1'($urandom) : 1'b0;
      mon_symb_cnt = 8'(n - 1);
      #1;
      chk("feed_s_rdy", s_din_rdy, dec_din_rdy);
      chk("feed_vld", dec_din_vld, s_din_vld);
      chk("feed_bit", dec_din, s_din);
      chk("feed_symb", dec_symb_cnt, k / nc);
      chk("feed_map", dec_map_type, mt);
      chk("feed_busy", frame_busy, 1);
      chk("feed_cfg_rdy", cfg_rdy, 0);
      if (s_din_vld && dec_din_rdy) k++;
      cyc++;
      if (cyc > 40 * stop_at + 50) begin
        chk("feed_budget", k, stop_at);
        break;
      end
    end
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic drain_check();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_din_vld = 1; dec_din_rdy = 1;
      #1;
      chk("drain_s_rdy", s_din_rdy, 0);
      chk("drain_vld", dec_din_vld, 0);
      chk("drain_busy", frame_busy, 1);
    end
    clear_in();
  endtask

  task automatic complete(input int n);
    if (n > 1) begin
      @(negedge clk);
      mon_vld = 1; mon_rdy = 1; mon_last = 1;
      mon_symb_cnt = 8'(n - 2);
      @(posedge clk); #1;
      clear_in();
      chk("mis_last_done", frame_done, 0);
      chk("mis_last_busy", frame_busy, 1);
    end
    @(negedge clk);
    mon_vld = 1; mon_rdy = 0; mon_last = 1; mon_symb_cnt = 8'(n - 1);
    @(posedge clk); #1;
    chk("nordy_done", frame_done, 0);
    mon_rdy = 1;
    @(posedge clk); #1;
    clear_in();
    chk("done_pulse", frame_done, 1);
    chk("done_cfg_rdy", cfg_rdy, 0);
    @(posedge clk); #1;
    chk("done_clear", frame_done, 0);
    chk("idle_cfg_rdy", cfg_rdy, 1);
    chk("idle_busy", frame_busy, 0);
  endtask

  vec_t vt[6];

  initial begin
    int j;
    int n, mt;
    vt[0] = '{1'b0, 8'd5,   2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'd0,   2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'd1,   2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 8'd255, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 8'd4,   2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 8'd0,   2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    clear_in();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_rdy", cfg_rdy, 1);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_symb", dec_symb_cnt, 0);
    chk("rst_map", dec_map_type, 0);
    chk("rst_s_rdy", s_din_rdy, 0);
    chk("rst_dvld", dec_din_vld, 0);
    @(negedge clk);
    rst = 0;

    // IDLE decisions from the vector table
    foreach (vt[i]) begin
      @(negedge clk);
      cfg_vld = vt[i].cv; cfg_n_symb = vt[i].n;
      cfg_map_type = vt[i].mt; s_din_vld = vt[i].sv;
      dec_din_rdy = vt[i].dr; abort = vt[i].ab;
      #1;
      chk("vec_cfg_rdy", cfg_rdy, 1);
      chk("vec_s_rdy", s_din_rdy, 0);
      chk("vec_dvld", dec_din_vld, 0);
      @(posedge clk); #1;
      clear_in();
      chk("vec_busy", frame_busy, vt[i].e_busy);
      chk("vec_err", frame_err, vt[i].e_err);
      chk("vec_done", frame_done, 0);
      @(negedge clk);
      abort = 1;
      @(posedge clk); #1;
      clear_in();
      chk("vec_back_idle", cfg_rdy, 1);
    end

    // BPSK, 2 symbols, continuous flow
    start_cfg(2, 0);
    feed(2, 0, 96, 1'b0);
    drain_check();
    complete(2);

    // zero-length config: error, never enters FEED
    start_cfg(0, 1);
    @(posedge clk); #1;
    chk("zero_err_clear", frame_err, 0);
    chk("zero_cfg_rdy", cfg_rdy, 1);

    // 64QAM, 3 symbols, random backpressure
    start_cfg(3, 3);
    feed(3, 3, 864, 1'b1);
    drain_check();
    complete(3);

    // wrong-count last ignored, then watchdog expires in DRAIN
    start_cfg(2, 0);
    feed(2, 0, 96, 1'b0);
    mon_vld = 1; mon_rdy = 1; mon_last = 1; mon_symb_cnt = 8'd0;
    j = 1;
    while (1) begin
      @(posedge clk); #1;
      clear_in();
      if (frame_err || j >= TO + 10) break;
      j++;
    end
    chk("timeout_cycles", j, TO);
    chk("timeout_no_done", frame_done, 0);
    @(posedge clk); #1;
    chk("timeout_err_clear", frame_err, 0);
    chk("timeout_cfg_rdy", cfg_rdy, 1);

    // abort mid-FEED at bit 50, with a handshake offered
    start_cfg(3, 1);
    feed(3, 1, 50, 1'b0);
    abort = 1; s_din_vld = 1; dec_din_rdy = 1;
    @(posedge clk); #1;
    clear_in();
    chk("abort_busy", frame_busy, 0);
    chk("abort_cfg_rdy", cfg_rdy, 1);
    chk("abort_done", frame_done, 0);
    chk("abort_err", frame_err, 0);
    chk("abort_symb", dec_symb_cnt, 0);
    @(posedge clk); #1;
    chk("abort_err2", frame_err, 0);
    start_cfg(1, 1);
    feed(1, 1, 96, 1'b1);
    drain_check();
    complete(1);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 3);
      mt = $urandom_range(0, 3);
      start_cfg(n, mt);
      feed(n, mt, n * ncbps(mt), 1'b1);
      drain_check();
      complete(n);
    end

    // asynchronous reset while draining
    start_cfg(1, 2);
    feed(1, 2, 192, 1'b0);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_busy", frame_busy, 0);
    chk("arst_cfg_rdy", cfg_rdy, 1);
    chk("arst_map", dec_map_type, 0);
    chk("arst_symb", dec_symb_cnt, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_cfg_rdy", cfg_rdy, 1);
    chk("post_rst_busy", frame_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
